// File: rtl/disp_seq_ctrl_if.sv
// Keypad-to-display bus for disp_seq_ctrl: key handshake plus the registered
// display and commit outputs.
interface disp_seq_ctrl_if;
    logic [3:0]  key_code;
    logic        key_vld;
    logic        key_rdy;
    logic [15:0] q;
    logic [3:0]  blank;
    logic [15:0] value;
    logic        done;

    modport master (
        output key_code, key_vld,
        input  key_rdy, q, blank, value, done
    );

    modport slave (
        input  key_code, key_vld,
        output key_rdy, q, blank, value, done
    );
endinterface

// File: rtl/disp_seq_ctrl.sv
// Four-digit keypad entry sequencer: collects BCD digits, commits them on enter
// and holds the committed value on the display. Optional macro DISP_BLINK_EN blinks it.
module disp_seq_ctrl #(
    parameter int HOLD_TICKS  = 50000000,
    parameter int BLINK_TICKS = 12500000
) (
    input  logic            ck1,
    input  logic            clr_n,
    disp_seq_ctrl_if.slave  bus
);

    if (HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_check
        $error("disp_seq_ctrl: HOLD_TICKS and BLINK_TICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] buffer_reg, buffer_next;
    logic [2:0]  count_reg, count_next;
    logic [15:0] value_reg, value_next;
    logic [31:0] hold_reg, hold_next;
    logic        done_next;

    logic [15:0] q_reg, q_next;
    logic [3:0]  blank_reg, blank_next;
    logic        rdy_reg, rdy_next;
    logic        done_reg;

    logic        accept;
    logic [3:0]  blank_entry;
    logic [3:0]  blank_hold;

    // The key is taken against the registered ready, so a key offered on the
    // cycle that enters HOLD is still accepted, and none during HOLD.
    assign accept = bus.key_vld & rdy_reg;

    // State register (also holds the registered outputs).
    always_ff @(posedge ck1 or negedge clr_n) begin
        if (!clr_n) begin
            state_reg  <= S_IDLE;
            buffer_reg <= 16'h0000;
            count_reg  <= 3'd0;
            value_reg  <= 16'h0000;
            hold_reg   <= 32'd0;
            q_reg      <= 16'h0000;
            blank_reg  <= 4'b1111;
            rdy_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buffer_reg <= buffer_next;
            count_reg  <= count_next;
            value_reg  <= value_next;
            hold_reg   <= hold_next;
            q_reg      <= q_next;
            blank_reg  <= blank_next;
            rdy_reg    <= rdy_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state_reg;
        buffer_next = buffer_reg;
        count_next  = count_reg;
        value_next  = value_reg;
        hold_next   = hold_reg;
        done_next   = 1'b0;
        case (state_reg)
            S_HOLD: begin
                if (hold_reg == 32'd0) begin
                    state_next  = S_IDLE;
                    buffer_next = 16'h0000;
                    count_next  = 3'd0;
                end else begin
                    hold_next = hold_reg - 32'd1;
                end
            end
            default: begin
                if (accept) begin
                    case (bus.key_code)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                            if (count_reg < 3'd4) begin
                                buffer_next = {buffer_reg[11:0], bus.key_code};
                                count_next  = count_reg + 3'd1;
                                state_next  = S_ENTRY;
                            end
                        end
                        4'hA: begin
                            if (count_reg != 3'd0) begin
                                value_next = buffer_reg;
                                done_next  = 1'b1;
                                state_next = S_HOLD;
                                hold_next  = 32'(HOLD_TICKS - 1);
                            end
                        end
                        4'hB: begin
                            if (count_reg != 3'd0) begin
                                buffer_next = {4'h0, buffer_reg[15:4]};
                                count_next  = count_reg - 3'd1;
                                state_next  = (count_reg == 3'd1) ? S_IDLE : S_ENTRY;
                            end
                        end
                        4'hC: begin
                            buffer_next = 16'h0000;
                            count_next  = 3'd0;
                            state_next  = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    // Digit n is dark once it lies beyond the number of entered digits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_blank
        assign blank_entry[gi] = (count_next <= 3'(gi));
    end

`ifdef DISP_BLINK_EN
    logic [31:0] blink_cnt_reg, blink_cnt_next;
    logic        blink_phase_reg, blink_phase_next;

    always_ff @(posedge ck1 or negedge clr_n) begin
        if (!clr_n) begin
            blink_cnt_reg   <= 32'd0;
            blink_phase_reg <= 1'b0;
        end else begin
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    // Phase restarts dark-free on every HOLD entry, then flips each BLINK_TICKS.
    always_comb begin
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;
        if (state_reg != S_HOLD && state_next == S_HOLD) begin
            blink_cnt_next   = 32'(BLINK_TICKS - 1);
            blink_phase_next = 1'b0;
        end else if (state_reg == S_HOLD) begin
            if (blink_cnt_reg == 32'd0) begin
                blink_cnt_next   = 32'(BLINK_TICKS - 1);
                blink_phase_next = ~blink_phase_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg - 32'd1;
            end
        end
    end

    assign blank_hold = {4{blink_phase_next}};
`else
    assign blank_hold = 4'b0000;
`endif

    // Output logic: registered outputs track the post-edge state.
    always_comb begin
        q_next     = buffer_next;
        blank_next = blank_entry;
        rdy_next   = 1'b1;
        if (state_next == S_HOLD) begin
            q_next     = value_next;
            blank_next = blank_hold;
            rdy_next   = 1'b0;
        end
    end

    assign bus.key_rdy = rdy_reg;
    assign bus.q       = q_reg;
    assign bus.blank   = blank_reg;
    assign bus.value   = value_reg;
    assign bus.done    = done_reg;

endmodule
